fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that owns the program counter, issues a request/acknowledge handshake to instruction memory and delivers one fetched instruction per cycle to the IF/ID pipeline latch. Its outputs are the instruction word, the instruction's PC and the sequential-or-predicted next PC (Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF on the latch side). It honours the shared STALL and takes redirects from branch resolution. An optional branch target buffer supplies next-PC predictions.

## Interface
- RESET_PC, 32'hBFC00000, PC loaded on reset
- BTB_IDX_W, 4, log2 of BTB entries (16 entries, direct-mapped, index = PC[BTB_IDX_W+1:2])
- CLK  in  1  clock, all state changes on rising edge
- RESET  in  1  reset; one clock; reset is asynchronous and active-low
- STALL  in  1  freeze delivery to downstream
- Redirect_EN  in  1  branch resolution/mispredict redirect
- Redirect_PC  in  32  redirect target
- Imem_Req  out  1  memory request valid
- Imem_Addr  out  32  request address
- Imem_Ack  in  1  response valid (completes current request)
- Imem_Data  in  32  response instruction word
- Instr1_OUT  out  32  fetched instruction (0 = NOP on bubble)
- Instr_PC_OUT  out  32  PC of Instr1_OUT
- Instr_PC_Plus4  out  32  next PC used by ID (predicted target or PC+4)
- Instr_Valid  out  1  Instr1_OUT is a real instruction
- Pred_Taken  out  1  next PC came from a taken BTB prediction
- Upd_EN  in  1  BTB update strobe from branch resolution
- Upd_PC  in  32  PC of resolved branch
- Upd_Target  in  32  resolved target
- Upd_Taken  in  1  resolved direction

## Operation
- States: FETCH, SQUASH, HOLD.
- FETCH: Imem_Req=1, Imem_Addr=PC. Address stays stable until Imem_Ack.
- On Ack with !STALL and !Redirect_EN:
  - Outputs load {Imem_Data, PC, NPC}, Instr_Valid=1, Pred_Taken=pred.
  - PC<=NPC; stay in FETCH.
- On Ack with STALL: response goes to a holding register with its NPC/pred; state HOLD.
- FETCH with no Ack and !STALL: bubble (Instr1_OUT=0, Instr_Valid=0, PC/NPC outputs hold).
- HOLD: Imem_Req=0. On !STALL, present the held entry (Instr_Valid=1), PC<=held NPC, go to FETCH.
- Redirect_EN has highest priority, including over STALL:
  - In FETCH with Ack the same cycle: drop the response, PC<=Redirect_PC, stay in FETCH.
  - In FETCH without Ack: latch Redirect_PC into pending reg, go to SQUASH. The request is not aborted.
  - In HOLD: discard the held entry, PC<=Redirect_PC, go to FETCH.
  - In SQUASH: pending reg is overwritten (last redirect wins).
  - Outputs go to bubble in the redirect cycle unless STALL, in which case they hold.
- SQUASH: Imem_Req=1 at the old address. On Ack, discard data, PC<=pending, go to FETCH. Never produces Instr_Valid=1.
- STALL with no Ack: all outputs hold their values.
- NPC = PC+4 (mod 2^32, wraps 32'hFFFFFFFC->0) unless a BTB prediction applies.

## Timing
- Reset (async, immediate): PC=RESET_PC, state FETCH, pending=0, all outputs 0 (including Instr_Valid and Pred_Taken).
- Imem_Req and Imem_Addr are combinational from state/PC, so Imem_Req=1 and Imem_Addr=RESET_PC in the first cycle after reset.
- Latency: Ack sampled at edge N appears on outputs after edge N. Back-to-back Acks give 1 instruction/cycle.
- Redirect at edge N: Imem_Addr=Redirect_PC from cycle N+1 (FETCH/HOLD), or from the cycle after the old Ack (SQUASH).
- Reset during SQUASH/HOLD: all state discarded; the outstanding response is ignored because state is FETCH at RESET_PC.
- BTB update is visible to a lookup in the following cycle. Same-index update and lookup in the same cycle use the old contents.

## Configuration
- BTB_EN defined:
  - Entry = valid, tag PC[31:BTB_IDX_W+2], target, 2-bit counter. Reset clears valid bits; counters reset to 01.
  - Lookup on PC: hit with counter>=2 gives NPC=target and pred=1.
  - Upd_EN on a miss: allocate with counter 10 if Upd_Taken, else leave the entry alone.
  - Upd_EN on a hit: counter saturating inc/dec; target written when taken.
- BTB_EN undefined: no BTB storage, NPC=PC+4, Pred_Taken tied 0, Upd_* ignored.

## Test plan
- Reset then Ack every cycle, Imem_Data=i -> Imem_Addr BFC00000, BFC00004, ...; Instr_PC_OUT follows one cycle later with Instr_Valid=1; Instr_PC_Plus4=PC+4.
- Ack arrives while STALL=1 for 3 cycles -> Imem_Req=0 during HOLD; held instruction appears with Instr_Valid=1 in the cycle after STALL drops; no instruction lost or duplicated.
- Redirect_EN to 0x00400100 while Ack is delayed by 2 cycles -> state SQUASH; first response discarded with Instr_Valid=0; next Imem_Addr=0x00400100.
- Redirect coincident with Ack at 0xBFC00008 -> data dropped; next Imem_Addr=Redirect_PC.
- BTB_EN: Upd_EN PC=0xBFC00010, target 0xBFC00100, taken -> next fetch of 0xBFC00010 gives Instr_PC_Plus4=0xBFC00100 and Pred_Taken=1; two not-taken updates -> falls back to PC+4.
- PC at 0xFFFFFFFC acked -> Instr_PC_Plus4=0x00000000; async reset asserted mid-SQUASH -> outputs 0 immediately, Imem_Addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory and feeds the IF/ID latch.
// Optional branch target buffer is compiled in when the BTB_EN macro is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFC00000,
    parameter int          BTB_IDX_W = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        Redirect_EN,
    input  logic [31:0] Redirect_PC,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Data,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4,
    output logic        Instr_Valid,
    output logic        Pred_Taken,
    input  logic        Upd_EN,
    input  logic [31:0] Upd_PC,
    input  logic [31:0] Upd_Target,
    input  logic        Upd_Taken
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_SQUASH = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]  state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] pend_r, pend_nxt_s;
    logic [31:0] hold_data_r, hold_npc_r;
    logic        hold_pred_r;
    logic        hold_load_s;
    logic        deliver_s;
    logic [31:0] dlv_data_s, dlv_npc_s;
    logic        dlv_pred_s;
    logic [31:0] npc_s;
    logic        pred_s;

    // The request is only withdrawn while a stalled response is parked in HOLD.
    assign Imem_Req  = (state_r != ST_HOLD);
    assign Imem_Addr = pc_r;

`ifdef BTB_EN
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 32 - BTB_IDX_W - 2;

    logic [BTB_N-1:0]     btb_valid_r;
    logic [TAG_W-1:0]     btb_tag_r [BTB_N];
    logic [31:0]          btb_tgt_r [BTB_N];
    logic [1:0]           btb_ctr_r [BTB_N];
    logic [BTB_IDX_W-1:0] lk_idx_s, up_idx_s;
    logic                 up_hit_s;

    assign lk_idx_s = pc_r[BTB_IDX_W+1:2];
    assign up_idx_s = Upd_PC[BTB_IDX_W+1:2];
    assign up_hit_s = btb_valid_r[up_idx_s] && (btb_tag_r[up_idx_s] == Upd_PC[31:BTB_IDX_W+2]);

    // Next-PC prediction from the current PC.
    always_comb begin
        pred_s = 1'b0;
        npc_s  = pc_r + 32'd4;
        if (btb_valid_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == pc_r[31:BTB_IDX_W+2])
            && btb_ctr_r[lk_idx_s][1]) begin
            pred_s = 1'b1;
            npc_s  = btb_tgt_r[lk_idx_s];
        end else begin
            pred_s = 1'b0;
            npc_s  = pc_r + 32'd4;
        end
    end

    // BTB training from resolved branches; writes land after the edge so same-cycle lookups see old data.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            btb_valid_r <= '0;
            for (int i = 0; i < BTB_N; i++) begin
                btb_tag_r[i] <= '0;
                btb_tgt_r[i] <= 32'd0;
                btb_ctr_r[i] <= 2'b01;
            end
        end else if (Upd_EN) begin
            if (up_hit_s) begin
                if (Upd_Taken) begin
                    btb_ctr_r[up_idx_s] <= (btb_ctr_r[up_idx_s] == 2'b11) ? 2'b11 : btb_ctr_r[up_idx_s] + 2'd1;
                    btb_tgt_r[up_idx_s] <= Upd_Target;
                end else begin
                    btb_ctr_r[up_idx_s] <= (btb_ctr_r[up_idx_s] == 2'b00) ? 2'b00 : btb_ctr_r[up_idx_s] - 2'd1;
                end
            end else if (Upd_Taken) begin
                btb_valid_r[up_idx_s] <= 1'b1;
                btb_tag_r[up_idx_s]   <= Upd_PC[31:BTB_IDX_W+2];
                btb_tgt_r[up_idx_s]   <= Upd_Target;
                btb_ctr_r[up_idx_s]   <= 2'b10;
            end
        end
    end
`else
    logic upd_unused_s;
    assign upd_unused_s = ^{Upd_EN, Upd_PC, Upd_Target, Upd_Taken, 32'(BTB_IDX_W)};
    assign pred_s = 1'b0;
    assign npc_s  = pc_r + 32'd4;
`endif

    // Fetch control: redirect outranks everything, including STALL.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        pend_nxt_s  = pend_r;
        hold_load_s = 1'b0;
        deliver_s   = 1'b0;
        dlv_data_s  = Imem_Data;
        dlv_npc_s   = npc_s;
        dlv_pred_s  = pred_s;
        case (state_r)
            ST_FETCH: begin
                if (Redirect_EN) begin
                    if (Imem_Ack) begin
                        pc_nxt_s = Redirect_PC;
                    end else begin
                        pend_nxt_s  = Redirect_PC;
                        state_nxt_s = ST_SQUASH;
                    end
                end else if (Imem_Ack) begin
                    if (STALL) begin
                        hold_load_s = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        deliver_s = 1'b1;
                        pc_nxt_s  = npc_s;
                    end
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_SQUASH: begin
                if (Imem_Ack) begin
                    pc_nxt_s    = Redirect_EN ? Redirect_PC : pend_r;
                    state_nxt_s = ST_FETCH;
                end else if (Redirect_EN) begin
                    pend_nxt_s = Redirect_PC;
                end else begin
                    state_nxt_s = ST_SQUASH;
                end
            end
            ST_HOLD: begin
                if (Redirect_EN) begin
                    pc_nxt_s    = Redirect_PC;
                    state_nxt_s = ST_FETCH;
                end else if (!STALL) begin
                    deliver_s   = 1'b1;
                    dlv_data_s  = hold_data_r;
                    dlv_npc_s   = hold_npc_r;
                    dlv_pred_s  = hold_pred_r;
                    pc_nxt_s    = hold_npc_r;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_FETCH;
                pc_nxt_s    = RESET_PC;
            end
        endcase
    end

    // Control state, PC, pending redirect and the parked response.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            pend_r      <= 32'd0;
            hold_data_r <= 32'd0;
            hold_npc_r  <= 32'd0;
            hold_pred_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            pend_r  <= pend_nxt_s;
            if (hold_load_s) begin
                hold_data_r <= Imem_Data;
                hold_npc_r  <= npc_s;
                hold_pred_r <= pred_s;
            end
        end
    end

    // IF/ID latch: STALL freezes it, otherwise deliver or insert a bubble (PC fields keep their values).
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Instr1_OUT     <= 32'd0;
            Instr_PC_OUT   <= 32'd0;
            Instr_PC_Plus4 <= 32'd0;
            Instr_Valid    <= 1'b0;
            Pred_Taken     <= 1'b0;
        end else if (!STALL) begin
            if (deliver_s) begin
                Instr1_OUT     <= dlv_data_s;
                Instr_PC_OUT   <= pc_r;
                Instr_PC_Plus4 <= dlv_npc_s;
                Instr_Valid    <= 1'b1;
                Pred_Taken     <= dlv_pred_s;
            end else begin
                Instr1_OUT  <= 32'd0;
                Instr_Valid <= 1'b0;
                Pred_Taken  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL, Redirect_EN, Imem_Ack, Upd_EN, Upd_Taken;
    logic [31:0] Redirect_PC, Imem_Data, Upd_PC, Upd_Target;
    logic        Imem_Req, Instr_Valid, Pred_Taken;
    logic [31:0] Imem_Addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL),
        .Redirect_EN(Redirect_EN), .Redirect_PC(Redirect_PC),
        .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
        .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data),
        .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT),
        .Instr_PC_Plus4(Instr_PC_Plus4), .Instr_Valid(Instr_Valid),
        .Pred_Taken(Pred_Taken), .Upd_EN(Upd_EN), .Upd_PC(Upd_PC),
        .Upd_Target(Upd_Target), .Upd_Taken(Upd_Taken)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: architectural PC, squash/hold flags, parked entry and expected latch contents.
    logic [31:0] m_pc, m_pend, h_data, h_npc;
    bit          m_sq, m_hd, h_pred;
    logic [31:0] e_instr, e_pc, e_npc;
    bit          e_valid, e_pred;
`ifdef BTB_EN
    bit          b_v   [16];
    logic [29:0] b_key [16];
    logic [31:0] b_tgt [16];
    int          b_cnt [16];
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'hBFC00000; m_pend = 32'd0; m_sq = 0; m_hd = 0;
        h_data = 32'd0; h_npc = 32'd0; h_pred = 0;
        e_instr = 32'd0; e_pc = 32'd0; e_npc = 32'd0; e_valid = 0; e_pred = 0;
`ifdef BTB_EN
        for (int i = 0; i < 16; i++) begin
            b_v[i] = 0; b_key[i] = 30'd0; b_tgt[i] = 32'd0; b_cnt[i] = 1;
        end
`endif
    endtask

    function automatic void predict(input logic [31:0] pc, output logic [31:0] npc, output bit taken);
        int idx;
        npc = pc + 32'd4;
        taken = 0;
        idx = int'(pc[5:2]);
`ifdef BTB_EN
        if (b_v[idx] && b_key[idx] == pc[31:2] && b_cnt[idx] >= 2) begin
            npc = b_tgt[idx];
            taken = 1;
        end
`endif
    endfunction

    task automatic model_train();
`ifdef BTB_EN
        int idx;
        idx = int'(Upd_PC[5:2]);
        if (Upd_EN) begin
            if (b_v[idx] && b_key[idx] == Upd_PC[31:2]) begin
                if (Upd_Taken) begin
                    b_cnt[idx] = (b_cnt[idx] < 3) ? b_cnt[idx] + 1 : 3;
                    b_tgt[idx] = Upd_Target;
                end else begin
                    b_cnt[idx] = (b_cnt[idx] > 0) ? b_cnt[idx] - 1 : 0;
                end
            end else if (Upd_Taken) begin
                b_v[idx] = 1; b_key[idx] = Upd_PC[31:2]; b_tgt[idx] = Upd_Target; b_cnt[idx] = 2;
            end
        end
`endif
    endtask

    task automatic check_outputs();
        chk("instr", Instr1_OUT, e_instr);
        chk("instr_pc", Instr_PC_OUT, e_pc);
        chk("instr_npc", Instr_PC_Plus4, e_npc);
        chk("valid", 32'(Instr_Valid), 32'(e_valid));
        chk("pred", 32'(Pred_Taken), 32'(e_pred));
    endtask

    // One clock: drive inputs, check the request side, step the model at the edge, then check the latch.
    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit ak, input logic [31:0] dat);
        logic [31:0] npc;
        bit          pt, deliver;
        logic [31:0] d_data, d_npc;
        bit          d_pred;
        logic [31:0] d_pc;
        STALL = st; Redirect_EN = rd; Redirect_PC = rpc; Imem_Ack = ak; Imem_Data = dat;
        #1;
        chk("imem_req", 32'(Imem_Req), 32'(!m_hd));
        chk("imem_addr", Imem_Addr, m_pc);
        @(posedge CLK);
        predict(m_pc, npc, pt);
        deliver = 0; d_data = 32'd0; d_pc = 32'd0; d_npc = 32'd0; d_pred = 0;
        if (rd) begin
            if (m_hd) begin m_hd = 0; m_pc = rpc; end
            else if (m_sq) begin
                if (ak) begin m_sq = 0; m_pc = rpc; end
                else m_pend = rpc;
            end else if (ak) m_pc = rpc;
            else begin m_sq = 1; m_pend = rpc; end
        end else if (m_hd) begin
            if (!st) begin
                deliver = 1; d_data = h_data; d_pc = m_pc; d_npc = h_npc; d_pred = h_pred;
                m_pc = h_npc; m_hd = 0;
            end
        end else if (m_sq) begin
            if (ak) begin m_pc = m_pend; m_sq = 0; end
        end else if (ak) begin
            if (st) begin m_hd = 1; h_data = dat; h_npc = npc; h_pred = pt; end
            else begin
                deliver = 1; d_data = dat; d_pc = m_pc; d_npc = npc; d_pred = pt;
                m_pc = npc;
            end
        end
        if (!st) begin
            if (deliver) begin
                e_instr = d_data; e_pc = d_pc; e_npc = d_npc; e_valid = 1; e_pred = d_pred;
            end else begin
                e_instr = 32'd0; e_valid = 0; e_pred = 0;
            end
        end
        model_train();
        #1;
        check_outputs();
        Upd_EN = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
        Upd_EN = 1'b1; Upd_PC = pc; Upd_Target = tgt; Upd_Taken = taken;
    endtask

    initial begin
        RESET = 1'b0; STALL = 1'b0; Redirect_EN = 1'b0; Redirect_PC = 32'd0;
        Imem_Ack = 1'b0; Imem_Data = 32'd0;
        Upd_EN = 1'b0; Upd_PC = 32'd0; Upd_Target = 32'd0; Upd_Taken = 1'b0;
        model_reset();
        #12;
        chk("lit_rst_addr", Imem_Addr, 32'hBFC00000);
        chk("lit_rst_req", 32'(Imem_Req), 32'd1);
        chk("lit_rst_valid", 32'(Instr_Valid), 32'd0);
        chk("lit_rst_instr", Instr1_OUT, 32'd0);
        RESET = 1'b1;

        // Sequential fetch.
        cycle(0, 0, 32'd0, 1, 32'h0000_0011);
        chk("lit_seq_pc", Instr_PC_OUT, 32'hBFC00000);
        chk("lit_seq_npc", Instr_PC_Plus4, 32'hBFC00004);
        chk("lit_seq_instr", Instr1_OUT, 32'h0000_0011);
        chk("lit_seq_addr", Imem_Addr, 32'hBFC00004);
        cycle(0, 0, 32'd0, 1, 32'h0000_0022);

        // Redirect coincident with Ack at BFC00008.
        chk("lit_addr8", Imem_Addr, 32'hBFC00008);
        cycle(0, 1, 32'h0040_0000, 1, 32'h0000_0099);
        chk("lit_rdack_valid", 32'(Instr_Valid), 32'd0);
        chk("lit_rdack_addr", Imem_Addr, 32'h0040_0000);

        // Redirect with a late Ack -> squash, then fetch at the new target.
        cycle(0, 1, 32'h0040_0100, 0, 32'd0);
        chk("lit_sq_addr", Imem_Addr, 32'h0040_0000);
        cycle(0, 0, 32'd0, 0, 32'd0);
        cycle(0, 0, 32'd0, 1, 32'hDEAD_BEEF);
        chk("lit_sq_valid", 32'(Instr_Valid), 32'd0);
        chk("lit_sq_next", Imem_Addr, 32'h0040_0100);

        // Ack during a three-cycle stall.
        cycle(1, 0, 32'd0, 1, 32'h0000_0033);
        chk("lit_hold_req", 32'(Imem_Req), 32'd0);
        cycle(1, 0, 32'd0, 0, 32'd0);
        cycle(1, 0, 32'd0, 0, 32'd0);
        cycle(0, 0, 32'd0, 0, 32'd0);
        chk("lit_hold_valid", 32'(Instr_Valid), 32'd1);
        chk("lit_hold_instr", Instr1_OUT, 32'h0000_0033);
        chk("lit_hold_pc", Instr_PC_OUT, 32'h0040_0100);
        chk("lit_hold_addr", Imem_Addr, 32'h0040_0104);

        // PC wrap at the top of the address space.
        cycle(0, 1, 32'hFFFF_FFFC, 1, 32'd0);
        cycle(0, 0, 32'd0, 1, 32'h0000_0044);
        chk("lit_wrap_pc", Instr_PC_OUT, 32'hFFFF_FFFC);
        chk("lit_wrap_npc", Instr_PC_Plus4, 32'h0000_0000);
        chk("lit_wrap_addr", Imem_Addr, 32'h0000_0000);

`ifdef BTB_EN
        set_upd(32'hBFC00010, 32'hBFC00100, 1'b1);
        cycle(0, 1, 32'hBFC00010, 1, 32'd0);
        cycle(0, 0, 32'd0, 1, 32'h0000_0055);
        chk("lit_btb_npc", Instr_PC_Plus4, 32'hBFC00100);
        chk("lit_btb_pred", 32'(Pred_Taken), 32'd1);
        chk("lit_btb_addr", Imem_Addr, 32'hBFC00100);
        set_upd(32'hBFC00010, 32'hBFC00100, 1'b0);
        cycle(0, 1, 32'hBFC00010, 1, 32'd0);
        set_upd(32'hBFC00010, 32'hBFC00100, 1'b0);
        cycle(0, 0, 32'd0, 0, 32'd0);
        cycle(0, 0, 32'd0, 1, 32'h0000_0066);
        chk("lit_btb_fall_npc", Instr_PC_Plus4, 32'hBFC00014);
        chk("lit_btb_fall_pred", 32'(Pred_Taken), 32'd0);
`endif

        // Asynchronous reset in the middle of a squash.
        cycle(0, 1, 32'h0040_0300, 0, 32'd0);
        #2 RESET = 1'b0;
        #1;
        chk("lit_arst_instr", Instr1_OUT, 32'd0);
        chk("lit_arst_pc", Instr_PC_OUT, 32'd0);
        chk("lit_arst_npc", Instr_PC_Plus4, 32'd0);
        chk("lit_arst_valid", 32'(Instr_Valid), 32'd0);
        chk("lit_arst_addr", Imem_Addr, 32'hBFC00000);
        model_reset();
        #1 RESET = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit          st, rd, ak;
            logic [31:0] rpc, dat;
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = 32'hBFC00000 + 32'(4 * $urandom_range(0, 31));
            ak  = !m_hd && ($urandom_range(0, 2) != 0);
            dat = $urandom;
            if ($urandom_range(0, 4) == 0)
                set_upd(32'hBFC00000 + 32'(4 * $urandom_range(0, 31)),
                        32'hBFC00000 + 32'(4 * $urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            cycle(st, rd, rpc, ak, dat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
